// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program store plus PC sequencer that issues 16-bit
// instructions over a valid/ready handshake. A run starts at address 0 and
// stops after issuing a HALT-opcode word or the last store entry.
// Optional build macro IIU_SINGLE_STEP_EN adds a step input and a PAUSE state
// so that each non-terminating handshake waits for a step pulse.
module instr_issue_unit #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    input  logic              instr_ready,
`ifdef IIU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [15:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

`ifdef IIU_SINGLE_STEP_EN
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DONE, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [15:0]       store [DEPTH];
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       instr_next;
    logic              valid_next;
    logic              done_next;
    logic              handshake;
    logic              last_word;

    assign pc_inc    = pc + 1'b1;
    assign handshake = instr_valid && instr_ready;
    assign last_word = (instruction[15:12] == HALT_OPCODE) || (pc == LAST_ADDR);

    // Program store: writable only while no run is in progress; not reset.
    always_ff @(posedge clk) begin
        if (load_en && (state == IDLE || state == DONE)) begin
            store[load_addr] <= load_data;
        end
    end

    // State and issue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instr_next;
            instr_valid <= valid_next;
            done        <= done_next;
        end
    end

    // Next-state and next-register values for the run sequencer.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instruction;
        valid_next = instr_valid;
        done_next  = done;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    pc_next    = '0;
                    done_next  = 1'b0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                instr_next = store[pc];
                valid_next = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (handshake) begin
                    if (last_word) begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        pc_next = pc_inc;
`ifdef IIU_SINGLE_STEP_EN
                        valid_next = 1'b0;
                        state_next = PAUSE;
`else
                        // Read ahead at pc+1 so the next word is ready the
                        // cycle after the handshake, giving back-to-back issue.
                        instr_next = store[pc_inc];
`endif
                    end
                end
            end
`ifdef IIU_SINGLE_STEP_EN
            PAUSE: begin
                if (step) begin
                    state_next = FETCH;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run-in-progress flag decoded from state.
    always_comb begin
        busy = (state == FETCH) || (state == ISSUE);
`ifdef IIU_SINGLE_STEP_EN
        if (state == PAUSE) begin
            busy = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit (default build): a directed vector
// table, a hand-written last-entry sequence, and randomized runs checked
// against a transaction-level model of the program store.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic        instr_ready;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    instr_issue_unit #(.DEPTH(16), .ADDR_W(4), .HALT_OPCODE(4'hF)) dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start(start),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc(pc),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        load_en;
        logic [3:0]  load_addr;
        logic [15:0] load_data;
        logic        start;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        chk_instr;
        logic [3:0]  e_pc;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic le, input logic [3:0] la,
                               input logic [15:0] ld, input logic st, input logic rdy,
                               input logic ev, input logic [15:0] ei, input logic ci,
                               input logic [3:0] ep, input logic eb, input logic ed);
        vec_t x;
        x.rst = r; x.load_en = le; x.load_addr = la; x.load_data = ld;
        x.start = st; x.ready = rdy; x.e_valid = ev; x.e_instr = ei;
        x.chk_instr = ci; x.e_pc = ep; x.e_busy = eb; x.e_done = ed;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; instr_ready = 1'b0;
    endtask

    // Reference store contents, tracked independently of the DUT.
    logic [15:0] model_mem [16];

    initial begin
        idle_inputs();

        // ---------------- directed vector table ----------------
        // reset for two cycles
        vecs.push_back(v(1,0,0,16'h0,0,0, 0,16'h0000,1,0,0,0));
        vecs.push_back(v(1,0,0,16'h0,0,0, 0,16'h0000,1,0,0,0));
        // load basic program
        vecs.push_back(v(0,1,0,16'h1234,0,0, 0,16'h0000,1,0,0,0));
        vecs.push_back(v(0,1,1,16'h2345,0,0, 0,16'h0000,1,0,0,0));
        vecs.push_back(v(0,1,2,16'hF000,0,0, 0,16'h0000,1,0,0,0));
        // basic run, ready held high
        vecs.push_back(v(0,0,0,16'h0,1,1, 0,16'h0000,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h2345,1,1,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hF000,1,2,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,2,0,1));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,2,0,1));
        // backpressure; blocked load and ignored start while busy
        vecs.push_back(v(0,0,0,16'h0,1,0, 0,16'h0000,0,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,0, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,1,1,16'hAAAA,0,0, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,1,0, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,0, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h2345,1,1,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hF000,1,2,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,2,0,1));
        // load accepted in DONE, restart issues the new word
        vecs.push_back(v(0,1,1,16'hAAAA,0,0, 0,16'h0000,0,2,0,1));
        vecs.push_back(v(0,0,0,16'h0,1,1, 0,16'h0000,0,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hAAAA,1,1,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hF000,1,2,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,2,0,1));
        // reset mid-run at pc=1, then restart with store intact
        vecs.push_back(v(0,0,0,16'h0,1,1, 0,16'h0000,0,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hAAAA,1,1,1,0));
        vecs.push_back(v(1,0,0,16'h0,0,1, 0,16'h0000,1,0,0,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,1,0,0,0));
        vecs.push_back(v(0,0,0,16'h0,1,1, 0,16'h0000,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'h1234,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hAAAA,1,1,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hF000,1,2,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,2,0,1));
        // load and start in the same cycle: the new word 0 (a HALT) is issued
        vecs.push_back(v(0,1,0,16'hF111,1,1, 0,16'h0000,0,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 1,16'hF111,1,0,1,0));
        vecs.push_back(v(0,0,0,16'h0,0,1, 0,16'h0000,0,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load_en = vecs[i].load_en;
            load_addr = vecs[i].load_addr; load_data = vecs[i].load_data;
            start = vecs[i].start; instr_ready = vecs[i].ready;
            tick();
            check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("row%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("row%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            if (vecs[i].chk_instr) begin
                check($sformatf("row%0d_instr", i), 32'(instruction), 32'(vecs[i].e_instr));
            end
        end
        idle_inputs();

        // ---------------- last entry: 16 words, no HALT ----------------
        for (int a = 0; a < 16; a++) begin
            load_en = 1'b1; load_addr = 4'(a); load_data = {4'h1, 12'(a * 37)};
            model_mem[a] = {4'h1, 12'(a * 37)};
            tick();
        end
        load_en = 1'b0;
        start = 1'b1; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        check("last_fetch_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("last_w%0d_valid", k), 32'(instr_valid), 32'd1);
            check($sformatf("last_w%0d_instr", k), 32'(instruction), 32'(model_mem[k]));
            check($sformatf("last_w%0d_pc", k), 32'(pc), 32'(k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("last_end%0d_done", k), 32'(done), 32'd1);
            check($sformatf("last_end%0d_valid", k), 32'(instr_valid), 32'd0);
            check($sformatf("last_end%0d_pc", k), 32'(pc), 32'd15);
        end
        instr_ready = 1'b0;

        // ---------------- randomized runs vs. store model ----------------
        for (int run = 0; run < 25; run++) begin
            logic [15:0] seq[$];
            int          n_loads;
            int          got;
            int          cycles;
            logic        rdy;

            // reprogram a few random addresses while idle/done
            n_loads = $urandom_range(0, 5);
            for (int j = 0; j < n_loads; j++) begin
                logic [3:0]  a;
                logic [15:0] d;
                a = 4'($urandom_range(0, 15));
                d = 16'($urandom);
                if ($urandom_range(0, 5) == 0) d[15:12] = 4'hF;
                else if (d[15:12] == 4'hF) d[15:12] = 4'h3;
                load_en = 1'b1; load_addr = a; load_data = d;
                model_mem[a] = d;
                tick();
            end
            load_en = 1'b0;

            // expected issue sequence: from address 0 through first HALT or last word
            seq.delete();
            for (int k = 0; k < 16; k++) begin
                seq.push_back(model_mem[k]);
                if (model_mem[k][15:12] == 4'hF) break;
            end

            start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("rnd%0d_fetch_valid", run), 32'(instr_valid), 32'd0);
            check($sformatf("rnd%0d_fetch_busy", run), 32'(busy), 32'd1);

            got = 0;
            cycles = 0;
            while (!done && cycles < 200) begin
                rdy = ($urandom_range(0, 2) != 0);
                instr_ready = rdy;
                // stray loads and starts during a run must have no effect
                load_en = ($urandom_range(0, 3) == 0);
                load_addr = 4'($urandom_range(0, 15));
                load_data = 16'($urandom);
                start = ($urandom_range(0, 4) == 0);
                check($sformatf("rnd%0d_busy", run), 32'(busy), 32'd1);
                if (instr_valid && rdy) begin
                    if (got < seq.size()) begin
                        check($sformatf("rnd%0d_w%0d_instr", run, got), 32'(instruction), 32'(seq[got]));
                    end else begin
                        check($sformatf("rnd%0d_extra_word", run), 32'(got), 32'(seq.size() - 1));
                    end
                    check($sformatf("rnd%0d_w%0d_pc", run, got), 32'(pc), 32'(got));
                    got++;
                end
                tick();
                cycles++;
            end
            idle_inputs();
            check($sformatf("rnd%0d_finished", run), 32'(done), 32'd1);
            check($sformatf("rnd%0d_count", run), 32'(got), 32'(seq.size()));
            check($sformatf("rnd%0d_end_pc", run), 32'(pc), 32'(seq.size() - 1));
            check($sformatf("rnd%0d_end_valid", run), 32'(instr_valid), 32'd0);
            check($sformatf("rnd%0d_end_busy", run), 32'(busy), 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Producer side of the 16-bit instruction interface consumed by the processor core.
- Instruction fields: opcode[15:12], src1[11:8], src2[7:4], dst[3:0].
- Holds a small program store, loaded word-by-word while the unit is idle.
- On start, sequences a PC through the store and issues one instruction per valid/ready handshake.
- Stops after issuing a HALT-opcode word or the last store entry, then reports done.

Parameters:
- DEPTH, 16, number of 16-bit program words.
- ADDR_W, 4, PC/load address width; DEPTH must equal 2**ADDR_W.
- HALT_OPCODE, 4'hF, opcode value that terminates a run.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load_en  input  1  write load_data into store at load_addr.
- load_addr  input  ADDR_W  store write address.
- load_data  input  16  instruction word to store.
- start  input  1  begin a run from address 0.
- instr_ready  input  1  consumer accepts the instruction this cycle.
- instruction  output  16  issued instruction word (registered).
- instr_valid  output  1  instruction is valid.
- pc  output  ADDR_W  address of the word currently on instruction.
- busy  output  1  run in progress (FETCH or ISSUE).
- done  output  1  run completed; held until the next start or rst.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - pc=0, instruction=16'h0000, instr_valid=0, busy=0, done=0.
  - Program store contents are not cleared.
  - rst in mid-run drops instr_valid the next cycle; no further words are issued.
- Store:
  - Register array, combinational read.
  - Written at the clk edge when load_en=1 and state is IDLE or DONE.
  - load_en in FETCH or ISSUE is ignored and does not modify the store.
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - start=1 -> pc<=0, done<=0, state FETCH.
  - A load and a start in the same cycle are both honoured; the write lands first, so the word at address 0 can be overwritten and issued in the same run.
- FETCH (exactly 1 cycle):
  - instruction<=store[pc], instr_valid<=1, state ISSUE.
  - Latency from start to instr_valid=1 is 2 cycles.
- ISSUE, instr_valid=1:
  - instruction and pc are held stable while instr_ready=0.
  - On handshake (instr_valid and instr_ready), if instruction[15:12]==HALT_OPCODE or pc==DEPTH-1:
    - instr_valid<=0, done<=1, state DONE.
    - pc holds its value; no wrap.
  - On handshake otherwise:
    - pc<=pc+1, instruction<=store[pc+1], instr_valid stays 1.
    - Throughput is back-to-back, one word per cycle while instr_ready=1.
- DONE:
  - done=1.
  - start=1 -> same action as start in IDLE (restart from address 0).
- start while busy=1 is ignored.
- busy=1 exactly in FETCH and ISSUE.
- The HALT word itself is issued to the consumer before the run stops.

Optional Feature:
- Macro: IIU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and a PAUSE state.
  - After each non-terminating handshake, go to PAUSE: instr_valid=0, pc already incremented, busy=1.
  - A step=1 pulse in PAUSE -> FETCH.
  - step outside PAUSE is ignored.
  - Terminating handshakes still go to DONE.
- Undefined:
  - No step port and no PAUSE state.
  - Issue is back-to-back as described above.

Test Plan:
- Reset values: assert rst for 2 cycles -> instr_valid=0, instruction=16'h0000, pc=0, busy=0, done=0.
- Basic run:
  - Load addr0=16'h1234, addr1=16'h2345, addr2=16'hF000; pulse start; instr_ready=1.
  - Expect 16'h1234, 16'h2345, 16'hF000 on consecutive cycles starting 2 cycles after start.
  - Next cycle: done=1, instr_valid=0, pc=2.
- Backpressure:
  - Same program with instr_ready=0 for 3 cycles after the first valid.
  - instruction holds 16'h1234 and pc holds 0; then issue resumes at 16'h2345 without loss or duplication.
- Last entry:
  - Fill all 16 words with opcode 4'h1 and no HALT; run with instr_ready=1.
  - Exactly 16 words are issued; done=1 with pc=15; no wrap to address 0.
- Load protection:
  - While busy, load_en=1 at addr1 with 16'hAAAA.
  - Issued word at pc=1 is unchanged; after DONE, the same write succeeds and a restart issues 16'hAAAA.
- Reset and restart:
  - Assert rst during ISSUE at pc=1 -> instr_valid=0 the next cycle.
  - After rst deasserts, start issues from address 0 with the store intact.
  - start pulsed while busy is ignored and pc is not reset.
